// File: rtl/axis_uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, parity/stop checks, multi-byte word packing onto an AXI4-Stream master.
// Optional AXIS_UART_RX_ERR_DROP_EN: words with a parity or framing error are discarded instead of delivered.
module axis_uart_rx #(
  parameter int unsigned AXI_DATA_WIDTH = 8,
  parameter int unsigned CLOCK          = 100_000_000,
  parameter int unsigned BAUD_RATE      = 115_200,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned PARITY_BITS    = 0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      uart_rx,
  output logic                      rx_done,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      overrun,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int unsigned COUNT_SPEED = CLOCK / BAUD_RATE;
  localparam int unsigned HALF_SPEED  = COUNT_SPEED / 2;
  localparam int unsigned CBW         = (COUNT_SPEED > 1) ? $clog2(COUNT_SPEED) : 1;
  localparam int unsigned BIT_MAX     = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int unsigned BTW         = $clog2(BIT_MAX + 1);
  localparam int unsigned NBYTES      = AXI_DATA_WIDTH / DATA_BITS;
  localparam int unsigned BYW         = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam bit          PAR_EVEN    = (PARITY_BITS != 0);
`ifdef AXIS_UART_RX_ERR_DROP_EN
  localparam bit          ERR_DROP    = 1'b1;
`else
  localparam bit          ERR_DROP    = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                    state_q;
  logic [1:0]                rx_sync_q;
  logic [CBW-1:0]            count_baud_q;
  logic [BTW-1:0]            count_bit_q;
  logic [BYW-1:0]            count_byte_q;
  logic [DATA_BITS-1:0]      byte_q;
  logic [AXI_DATA_WIDTH-1:0] word_q;
  logic [AXI_DATA_WIDTH-1:0] tdata_q;
  logic                      tvalid_q;
  logic                      par_err_q, frm_err_q;
  logic                      rx_done_q, parity_err_q, frame_err_q, overrun_q;

  logic rx_s, half_end, baud_end, exp_par, last_byte, frm_now, drop_word;

  assign rx_s      = rx_sync_q[1];
  assign half_end  = (count_baud_q == CBW'(HALF_SPEED - 1));
  assign baud_end  = (count_baud_q == CBW'(COUNT_SPEED - 1));
  assign exp_par   = PAR_EVEN ? (^byte_q) : ~(^byte_q);
  assign last_byte = (count_byte_q == BYW'(NBYTES - 1));
  assign frm_now   = frm_err_q | ~rx_s;
  assign drop_word = ERR_DROP & (par_err_q | frm_now);

  // Line synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rx_sync_q <= 2'b11;
    else          rx_sync_q <= {rx_sync_q[0], uart_rx};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      count_baud_q <= '0;
      count_bit_q  <= '0;
      count_byte_q <= '0;
      byte_q       <= '0;
      word_q       <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      if (tvalid_q && m_axis_tready) tvalid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q      <= START;
            count_baud_q <= '0;
          end
        end
        // Re-check the start bit at mid-bit to reject glitches.
        START: begin
          if (half_end) begin
            count_baud_q <= '0;
            count_bit_q  <= '0;
            state_q      <= rx_s ? IDLE : DATA;
          end else begin
            count_baud_q <= count_baud_q + CBW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            count_baud_q <= '0;
            byte_q       <= {rx_s, byte_q[DATA_BITS-1:1]};
            if (count_bit_q == BTW'(DATA_BITS - 1)) begin
              count_bit_q <= '0;
              state_q     <= PARITY;
            end else begin
              count_bit_q <= count_bit_q + BTW'(1);
            end
          end else begin
            count_baud_q <= count_baud_q + CBW'(1);
          end
        end
        // Earlier bytes shift toward the MSB so byte 0 ends in the top slot.
        PARITY: begin
          if (baud_end) begin
            count_baud_q <= '0;
            count_bit_q  <= '0;
            par_err_q    <= par_err_q | (rx_s != exp_par);
            word_q       <= (word_q << DATA_BITS) | AXI_DATA_WIDTH'(byte_q);
            state_q      <= STOP;
          end else begin
            count_baud_q <= count_baud_q + CBW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            count_baud_q <= '0;
            if (count_bit_q == BTW'(STOP_BITS - 1)) begin
              count_bit_q <= '0;
              state_q     <= IDLE;
              if (!last_byte) begin
                count_byte_q <= count_byte_q + BYW'(1);
                frm_err_q    <= frm_now;
              end else begin
                count_byte_q <= '0;
                par_err_q    <= 1'b0;
                frm_err_q    <= 1'b0;
                parity_err_q <= par_err_q;
                frame_err_q  <= frm_now;
                if (!drop_word) begin
                  if (!tvalid_q || m_axis_tready) begin
                    tdata_q   <= word_q;
                    tvalid_q  <= 1'b1;
                    rx_done_q <= 1'b1;
                  end else begin
                    overrun_q <= 1'b1;
                  end
                end
              end
            end else begin
              count_bit_q <= count_bit_q + BTW'(1);
              frm_err_q   <= frm_now;
            end
          end else begin
            count_baud_q <= count_baud_q + CBW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign rx_done       = rx_done_q;
  assign parity_err    = parity_err_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Scoreboard bench for axis_uart_rx: 16-bit words of two 8-bit bytes, even parity, 16 clocks per bit.
module tb_axis_uart_rx;

  localparam int unsigned AW  = 16;
  localparam int unsigned CS  = 16;
  localparam int unsigned SB  = 1;
  localparam bit          EVEN = 1'b1;
`ifdef AXIS_UART_RX_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct packed {
    logic          rd;
    logic          pe;
    logic          fe;
    logic          ov;
    logic [AW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          uart_rx = 1'b1;
  logic          rx_done, parity_err, frame_err, overrun;
  logic [AW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;

  ev_t           exp_q[$];
  logic [AW-1:0] acc_q[$];
  bit            held_model = 1'b0;
  int            checks = 0;
  int            passes = 0;
  ev_t           mon_e;

  always #5 clk = ~clk;

  axis_uart_rx #(
    .AXI_DATA_WIDTH(AW), .CLOCK(1600), .BAUD_RATE(100),
    .DATA_BITS(8), .STOP_BITS(SB), .PARITY_BITS(1)
  ) dut (
    .aclk(clk), .aresetn(aresetn), .uart_rx(uart_rx),
    .rx_done(rx_done), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic line(input logic v, input int n);
    uart_rx = v;
    cyc(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = EVEN ? (^b) : ~(^b);
    line(1'b0, CS);
    for (int i = 0; i < 8; i++) line(b[i], CS);
    line(p ^ bad_par, CS);
    for (int s = 0; s < SB; s++) line((bad_stop && s == 0) ? 1'b0 : 1'b1, CS);
    uart_rx = 1'b1;
  endtask

  // Model: a word is delivered unless dropped for errors; it overruns if the previous one is still held.
  task automatic expect_word(input logic [AW-1:0] w, input bit pe, input bit fe);
    ev_t e;
    e = '{rd: 1'b0, pe: pe, fe: fe, ov: 1'b0, data: w};
    if (!(DROP && (pe || fe))) begin
      if (held_model) e.ov = 1'b1;
      else begin
        e.rd = 1'b1;
        acc_q.push_back(w);
        held_model = !m_axis_tready;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [AW-1:0] w, input logic [1:0] pmask, input bit bad_stop);
    expect_word(w, |pmask, bad_stop);
    for (int k = 0; k < AW / 8; k++)
      send_byte(w[AW-1-8*k -: 8], pmask[k], bad_stop && (k == AW / 8 - 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && n < 3000) begin
      cyc(1);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size() + acc_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk(name, {rx_done, parity_err, frame_err, overrun, m_axis_tvalid}, 32'd0);
  endtask

  // Monitor: pops an expected event for every pulse and an expected beat for every handshake.
  always @(negedge clk) begin
    if (aresetn) begin
      if (rx_done || parity_err || frame_err || overrun) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {rx_done, parity_err, frame_err, overrun}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("event_flags", {rx_done, parity_err, frame_err, overrun},
              {mon_e.rd, mon_e.pe, mon_e.fe, mon_e.ov});
          if (mon_e.rd) chk("load_tdata", m_axis_tdata, mon_e.data);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (acc_q.size() == 0) chk("unexpected_beat", m_axis_tvalid, 32'd0);
        else chk("beat_tdata", m_axis_tdata, acc_q.pop_front());
      end
    end
  end

  initial begin
    cyc(4);
    chk("reset_tdata", m_axis_tdata, 32'd0);
    check_idle_outputs("reset_outputs");
    aresetn = 1'b1;
    cyc(4);
    check_idle_outputs("post_reset_outputs");

    send_word(16'hA5A5, 2'b00, 1'b0);
    cyc(3);
    send_word(16'h1234, 2'b00, 1'b0);
    send_word(16'h3C3C, 2'b10, 1'b0);
    cyc(5);
    send_word(16'h5555, 2'b00, 1'b1);
    cyc(2 * CS);
    send_word(16'h6666, 2'b00, 1'b0);
    drain();

    // Short low glitch must be rejected at mid start bit.
    line(1'b0, 5);
    line(1'b1, 3 * CS);
    check_idle_outputs("glitch_quiet");
    send_word(16'h8181, 2'b00, 1'b0);
    drain();

    // Overrun: second word discarded while the first is held.
    m_axis_tready = 1'b0;
    send_word(16'h1111, 2'b00, 1'b0);
    cyc(10);
    send_word(16'h2222, 2'b00, 1'b0);
    cyc(20);
    chk("held_tdata", m_axis_tdata, 32'h1111);
    chk("held_tvalid", m_axis_tvalid, 32'd1);
    m_axis_tready = 1'b1;
    held_model = 1'b0;
    drain();
    chk("tvalid_cleared", m_axis_tvalid, 32'd0);

    // Reset in the middle of a frame discards the partial word.
    line(1'b0, 3 * CS);
    aresetn = 1'b0;
    cyc(3);
    check_idle_outputs("midframe_reset");
    uart_rx = 1'b1;
    cyc(3);
    aresetn = 1'b1;
    cyc(2 * CS);
    send_word(16'hC3E7, 2'b00, 1'b0);
    drain();

    for (int i = 0; i < 24; i++) begin
      logic [AW-1:0] w;
      logic [1:0]    pm;
      bit            bs;
      w  = AW'($urandom);
      pm = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bs = ($urandom_range(0, 5) == 0);
      send_word(w, pm, bs);
      cyc(bs ? (2 * CS + $urandom_range(0, 10)) : $urandom_range(0, 20));
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axis_uart_rx.md
# axis_uart_rx

UART receiver that deserialises the line driven by `axis_uart_tx` and presents each completed word on an AXI4-Stream master interface. It is the consuming stage of the UART link. Its frame format, multi-byte word packing and parity convention mirror the transmitter exactly, so a looped-back TX/RX pair returns every word unchanged. It synchronises and oversamples the line, checks parity and stop bits, and holds one completed word until the downstream sink accepts it.

## Interface
- `AXI_DATA_WIDTH`, 8, width of `m_axis.tdata`; must be a multiple of `DATA_BITS`.
- `CLOCK`, 100_000_000, `aclk` frequency in Hz.
- `BAUD_RATE`, 115_200, line rate; `COUNT_SPEED = CLOCK/BAUD_RATE` clocks per bit.
- `DATA_BITS`, 8, data bits per UART byte.
- `STOP_BITS`, 1, stop bits per byte.
- `PARITY_BITS`, 0, parity sense: 1 = even (bit = XOR of data), 0 = odd (bit = inverted XOR); the parity bit is always present on the line.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous assert, active-low.
- `uart_rx`  in  1  serial line, asynchronous to `aclk`, idle high.
- `rx_done`  out  1  one-cycle pulse when a word is loaded into the output register.
- `parity_err`  out  1  one-cycle pulse when any byte of the current word fails parity.
- `frame_err`  out  1  one-cycle pulse when any sampled stop bit is low.
- `overrun`  out  1  one-cycle pulse when a completed word is discarded because the output register is still full.
- `m_axis`  `axis_if.m_axis`  AXI_DATA_WIDTH  `tdata`, `tvalid` out; `tready` in.

## Operation
- `uart_rx` passes through a 2-flop synchroniser. All decisions use the synchronised value `rx_s`. The synchroniser flops reset to 1.
- States: IDLE, START, DATA, PARITY, STOP. Counters: `count_baud`, `count_bit`, `count_byte` (0..AXI_DATA_WIDTH/DATA_BITS-1).
- IDLE: when `rx_s` is 0, go to START with `count_baud` = 0.
- START: at `count_baud == COUNT_SPEED/2-1` (mid-bit):
  - `rx_s` = 1 → glitch; return to IDLE. No flags raised; `count_byte` unchanged.
  - `rx_s` = 0 → go to DATA with the counter cleared.
- From START onward, every sample is taken at `count_baud == COUNT_SPEED-1`, i.e. the middle of each subsequent bit.
- DATA: sample `DATA_BITS` bits LSB-first into the byte slot. Byte `k` (0 = first received) occupies `tdata[AXI_DATA_WIDTH-1-k*DATA_BITS -: DATA_BITS]`, so the first byte lands in the most-significant slot. Then go to PARITY.
- PARITY: sample one bit and compare it with the expected parity per `PARITY_BITS`. A mismatch sets a sticky word-error bit for parity.
- STOP: sample `STOP_BITS` bits. Any 0 sets a sticky framing bit. After the last stop sample:
  - If this is not the last byte: increment `count_byte` and return to IDLE to hunt the next start bit. There is no inter-byte timeout.
  - If this is the last byte: the word is complete. Clear `count_byte`, fire the error pulses for any sticky bits, clear the sticky bits, and return to IDLE.
- Output register (single entry): on word completion,
  - if `tvalid` = 0, or `tvalid & tready` in the same cycle: load `tdata`, set `tvalid`, pulse `rx_done`;
  - otherwise: discard the new word, pulse `overrun`, and leave the held word unchanged.
- `tvalid` stays high, with `tdata` stable, until `tvalid & tready`, then clears on the next edge.
- Reset asserted mid-frame: all outputs and counters return to reset values and the state returns to IDLE. Any partial word is lost.

## Timing
- Reset values: `tvalid` 0, `tdata` 0, `rx_done`/`parity_err`/`frame_err`/`overrun` 0, state IDLE.
- Latency: `tvalid` and the pulses assert 1 cycle after the final stop-bit sample of the last byte. That sample falls 2 synchroniser cycles plus roughly mid-bit after the line transition.
- The receiver can accept back-to-back bytes with zero idle time between the stop bit and the next start bit. The return to IDLE is ½ bit early, so the next start edge is caught.
- `tready` has no combinational path to any output.

## Configuration
- `AXIS_UART_RX_ERR_DROP_EN` defined: a word with a parity or framing error is not loaded, so no `tvalid` and no `rx_done`. Only the error pulses fire, and it cannot cause `overrun`.
- Macro undefined: an errored word is delivered normally, with `rx_done` and the error pulses in the same cycle.

## Test plan
- Defaults (COUNT_SPEED = 868), `PARITY_BITS=1`, send 0xA5 with parity 0 and stop 1, `tready` = 1 → `tdata` = 0xA5, `tvalid` high for 1 cycle, `rx_done` pulse, no errors.
- `AXI_DATA_WIDTH=16`, send bytes 0x12 then 0x34 back-to-back → a single word `tdata` = 0x1234, one `rx_done`.
- Send 0x3C with the wrong parity bit → `parity_err` pulse. Without the macro, `tdata` = 0x3C with `tvalid`. With the macro, `tvalid` stays 0.
- Send 0x55 with the stop bit driven 0 → `frame_err` pulse. The next correctly framed 0x66 is received cleanly.
- Drive a 300-cycle low glitch on an idle line → no state advance, no `tvalid`, no pulses. A following 0x81 is received as 0x81.
- Hold `tready` = 0 and send 0x11 then 0x22 → `tdata` stays 0x11 and `overrun` pulses once. Raising `tready` then yields 0x11 only.
